// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and widths for the hazard stall unit
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/mem_wait_fsm.sv
// rtl/mem_wait_fsm.sv - data-memory wait-state FSM with timeout watchdog
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic MemReqM,
  input  logic MemAckM,
  output logic memStall,
  output logic MemErr
);

  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // State and wait-counter registers; reset returns to RUN with an empty counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and stall decode; the counter stops at the limit so it never wraps
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    memStall  = 1'b0;
    MemErr    = 1'b0;
    case (state)
      RUN: begin
        // An ack arriving with the request completes in place; a lone ack is ignored
        if (MemReqM && !MemAckM) begin
          memStall  = 1'b1;
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          memStall = 1'b1;
          if (cnt == CNT_LIMIT) begin
            state_nxt = MEM_ERR;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      MEM_ERR: begin
        // Absorbing: the pipeline stays frozen until reset
        memStall = 1'b1;
        MemErr   = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline stall/flush control; HAZARD_PERF_EN adds stall counters
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic                  MemReadE,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemAckM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MemErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] LuStallCnt,
  output logic [PERF_CNT_W-1:0] MemStallCnt
`endif
);

  logic fsm_stall;
  logic fsm_err;
  logic lw_hit;
  logic lw_stall;
  logic mem_stall;
  logic br_taken;

  mem_wait_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .rst      (rst),
    .MemReqM  (MemReqM),
    .MemAckM  (MemAckM),
    .memStall (fsm_stall),
    .MemErr   (fsm_err)
  );

  // Load-use compare gated by reset so every output is quiet while reset is held
  always_comb begin
    lw_hit    = MemReadE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    lw_stall  = rst && lw_hit;
    mem_stall = rst && fsm_stall;
    br_taken  = rst && PCSrcE;
  end

  // Output equations; a frozen Execute defers any branch flush until the memory stall falls
  always_comb begin
    StallF = lw_stall || mem_stall;
    StallD = lw_stall || mem_stall;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushW = mem_stall;
    FlushE = (lw_stall || br_taken) && !mem_stall;
    FlushD = br_taken && !mem_stall;
    MemErr = rst && fsm_err;
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters for load-use bubbles and memory-wait cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LuStallCnt  <= '0;
      MemStallCnt <= '0;
    end else begin
      if (lw_stall && !mem_stall && (LuStallCnt != '1)) begin
        LuStallCnt <= LuStallCnt + 1'b1;
      end
      if (mem_stall && (MemStallCnt != '1)) begin
        MemStallCnt <= MemStallCnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, RD_E;
  logic       MemReadE, PCSrcE, MemReqM, MemAckM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [7:0] outs;
`ifdef HAZARD_PERF_EN
  logic [31:0] LuStallCnt, MemStallCnt;
`endif

  int errors = 0;
  int checks = 0;

  // reference model: consecutive unacked wait cycles, sticky error, event counts
  int          m_wait;
  bit          m_err;
  int unsigned m_lu;
  int unsigned m_ms;

  always #5 clk = ~clk;

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};

  hazard_stall_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
    , .LuStallCnt(LuStallCnt), .MemStallCnt(MemStallCnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_lw();
    return MemReadE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
  endfunction

  function automatic bit m_mstall();
    return m_err || ((m_wait > 0 || MemReqM) && !MemAckM);
  endfunction

  function automatic logic [7:0] m_outs();
    bit lw, ms;
    lw = m_lw();
    ms = m_mstall();
    return {lw | ms, lw | ms, ms, ms, PCSrcE & !ms, (lw | PCSrcE) & !ms, ms, m_err};
  endfunction

  task automatic m_reset();
    m_wait = 0;
    m_err  = 0;
    m_lu   = 0;
    m_ms   = 0;
  endtask

  task automatic drive(input bit mre, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input bit pc, input bit req, input bit ack);
    MemReadE = mre; RD_E = rd; Rs1_D = r1; Rs2_D = r2;
    PCSrcE = pc; MemReqM = req; MemAckM = ack;
    #1;
  endtask

  // compare against the model, cross the clock edge, advance the model
  task automatic tick(input string tag);
    bit lw, ms;
    chk(tag, {24'd0, outs}, {24'd0, m_outs()});
`ifdef HAZARD_PERF_EN
    chk({tag, "_lucnt"}, LuStallCnt, m_lu);
    chk({tag, "_mscnt"}, MemStallCnt, m_ms);
`endif
    lw = m_lw();
    ms = m_mstall();
    @(posedge clk);
    if (lw && !ms) m_lu++;
    if (ms) m_ms++;
    if (!m_err) begin
      if (ms) begin
        m_wait++;
        if (m_wait == T + 1) m_err = 1;
      end else begin
        m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    chk(tag, {24'd0, outs}, 32'd0);
`ifdef HAZARD_PERF_EN
    chk({tag, "_cnt"}, LuStallCnt | MemStallCnt, 32'd0);
`endif
    m_reset();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    m_reset();
    rst = 1'b0;
    drive(1, 5'd5, 5'd5, 5'd0, 1, 1, 0);
    #1;
    chk("reset_outs", {24'd0, outs}, 32'd0);
    rst = 1'b1;

    // load-use: one stall, then the load has moved on
    drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    chk("lu_vec", {24'd0, outs}, 32'b1100_0100);
    tick("lu_cyc");
    drive(0, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    chk("lu_after", {24'd0, outs}, 32'd0);
    tick("lu_after_cyc");
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("lu_x0", {24'd0, outs}, 32'd0);
    tick("lu_x0_cyc");
    drive(1, 5'd7, 5'd3, 5'd7, 0, 0, 0);
    chk("lu_rs2", {24'd0, outs}, 32'b1100_0100);
    tick("lu_rs2_cyc");

    // taken branch
    drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    chk("branch", {24'd0, outs}, 32'b0000_1100);
    tick("branch_cyc");

    // branch together with load-use
    drive(1, 5'd9, 5'd9, 5'd0, 1, 0, 0);
    chk("branch_lu", {24'd0, outs}, 32'b1100_1100);
    tick("branch_lu_cyc");

    // three-cycle memory wait, released in the ack cycle
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      chk("memwait", {24'd0, outs}, 32'b1111_0010);
      tick("memwait_cyc");
    end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    chk("memwait_ack", {24'd0, outs}, 32'd0);
    tick("memwait_ack_cyc");

    // same-cycle ack, then a lone ack in RUN
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    chk("same_ack", {24'd0, outs}, 32'd0);
    tick("same_ack_cyc");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    chk("lone_ack", {24'd0, outs}, 32'd0);
    tick("lone_ack_cyc");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("idle", {24'd0, outs}, 32'd0);
    tick("idle_cyc");

    // branch held through a two-cycle wait is flushed in the ack cycle
    for (int i = 0; i < 2; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
      chk("br_wait", {24'd0, outs}, 32'b1111_0010);
      tick("br_wait_cyc");
    end
    drive(0, 5'd0, 5'd0, 5'd0, 1, 1, 1);
    chk("br_wait_ack", {24'd0, outs}, 32'b0000_1100);
    tick("br_wait_ack_cyc");

    // perf scenario: two load-use hazards and one four-cycle wait
    async_reset("perf_rst");
    drive(1, 5'd4, 5'd4, 5'd0, 0, 0, 0); tick("perf_lu1");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0); tick("perf_gap");
    drive(1, 5'd6, 5'd0, 5'd6, 0, 0, 0); tick("perf_lu2");
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); tick("perf_wait");
    end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1); tick("perf_ack");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("perf_lu_total", LuStallCnt, 32'd2);
    chk("perf_ms_total", MemStallCnt, 32'd4);
`endif
    tick("perf_idle");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      tick("rand");
    end

    // timeout: error after TIMEOUT_CYCLES+1 unacked cycles, then sticky
    async_reset("to_rst");
    for (int i = 0; i < T; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      tick("to_wait");
    end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    chk("to_not_yet", {31'd0, MemErr}, 32'd0);
    tick("to_last");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    chk("to_err", {24'd0, outs}, 32'b1111_0011);
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd2, 5'd2, 5'd0, 1, 1, 1);
      chk("to_sticky", {24'd0, outs}, 32'b1111_0011);
      tick("to_sticky_cyc");
    end
    async_reset("to_clear");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("post_reset", {24'd0, outs}, 32'd0);
    tick("post_reset_cyc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
